// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit ALU op codes, RV32I opcode/funct constants,
// widths and immediate-extraction helpers. Used by the issue stage and the ALU.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned F7_W  = 7;
  localparam int unsigned SH_W  = 5;

  // ALU operation encoding seen on alu_control
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  // RV32I major opcodes handled by the issue stage
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;

  // funct7 values: base encoding and the SUB/SRA alternate
  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  // funct3 values shared by OP and OP-IMM
  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_SR   = 3'b101;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;

  // Payload held in the EX pipeline register
  typedef struct packed {
    logic [XLEN-1:0]  operand_a;
    logic [XLEN-1:0]  operand_b;
    alu_op_e          alu_control;
    logic [REG_W-1:0] rd;
    logic             illegal;
  } issue_bundle_t;

  // I-type immediate, sign-extended
  function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] instr);
    return {{(XLEN-12){instr[31]}}, instr[31:20]};
  endfunction

  // U-type immediate, low 12 bits zero
  function automatic logic [XLEN-1:0] imm_u(input logic [XLEN-1:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  // Shift amount for SLLI/SRLI/SRAI, zero-extended
  function automatic logic [XLEN-1:0] imm_sh(input logic [XLEN-1:0] instr);
    return {{(XLEN-SH_W){1'b0}}, instr[24:20]};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction/operand input handshake, registered ALU operand
// outputs with the combinational ALU response, and the writeback handshake.
//   master : environment side (drives bundles, ALU response, wb_ready)
//   slave  : alu_issue side (drives in_ready, operands, writeback payload)
interface alu_issue_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  instr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;

  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  alu_op_e          alu_control;
  logic [XLEN-1:0]  alu_result;
  logic             zero_flag;

  logic             wb_valid;
  logic             wb_ready;
  logic [REG_W-1:0] wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             wb_zero;
  logic             wb_illegal;

  modport master (
    output in_valid, instr, rs1_data, rs2_data, alu_result, zero_flag, wb_ready,
    input  in_ready, operand_a, operand_b, alu_control,
           wb_valid, wb_rd, wb_data, wb_zero, wb_illegal
  );

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, alu_result, zero_flag, wb_ready,
    output in_ready, operand_a, operand_b, alu_control,
           wb_valid, wb_rd, wb_data, wb_zero, wb_illegal
  );

endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I decode for OP, OP-IMM and LUI into ALU operands and op.
//   instr, rs1_data, rs2_data : instruction word and register-file reads
//   operand_a, operand_b      : ALU operands (zero for illegal encodings)
//   alu_control               : ALU op (ADD for illegal encodings)
//   rd                        : destination register, always instr[11:7]
//   illegal                   : encoding not supported by this stage
module alu_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]  instr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  operand_a,
  output logic [XLEN-1:0]  operand_b,
  output alu_op_e          alu_control,
  output logic [REG_W-1:0] rd,
  output logic             illegal
);

  logic [OPC_W-1:0] opcode;
  logic [F3_W-1:0]  funct3;
  logic [F7_W-1:0]  funct7;
  logic             legal;
  alu_op_e          op;
  logic [XLEN-1:0]  opa;
  logic [XLEN-1:0]  opb;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  // Raw decode; an unsupported encoding just clears legal
  always_comb begin
    legal = 1'b0;
    op    = ALU_ADD;
    opa   = rs1_data;
    opb   = rs2_data;
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == F7_BASE);
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_ALT) begin
              op    = ALU_SUB;
              legal = 1'b1;
            end else begin
              op = ALU_ADD;
            end
          end
          F3_SLL:  op = ALU_SLL;
          F3_SLT:  op = ALU_SLT;
          F3_SLTU: op = ALU_SLTU;
          F3_XOR:  op = ALU_XOR;
          F3_SR: begin
            if (funct7 == F7_ALT) begin
              op    = ALU_SRA;
              legal = 1'b1;
            end else begin
              op = ALU_SRL;
            end
          end
          F3_OR:   op = ALU_OR;
          F3_AND:  op = ALU_AND;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal = 1'b1;
        opb   = imm_i(instr);
        case (funct3)
          F3_ADD:  op = ALU_ADD;
          F3_SLT:  op = ALU_SLT;
          F3_SLTU: op = ALU_SLTU;
          F3_XOR:  op = ALU_XOR;
          F3_OR:   op = ALU_OR;
          F3_AND:  op = ALU_AND;
          F3_SLL: begin
            op    = ALU_SLL;
            opb   = imm_sh(instr);
            legal = (funct7 == F7_BASE);
          end
          F3_SR: begin
            opb = imm_sh(instr);
            if (funct7 == F7_ALT) begin
              op = ALU_SRA;
            end else begin
              op    = ALU_SRL;
              legal = (funct7 == F7_BASE);
            end
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        op    = ALU_ADD;
        opa   = '0;
        opb   = imm_u(instr);
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal bundles still flow down the pipe as 0 + 0 so wb_data reads 0
  always_comb begin
    operand_a   = legal ? opa : '0;
    operand_b   = legal ? opb : '0;
    alu_control = legal ? op  : ALU_ADD;
    illegal     = !legal;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an accepted instruction into the EX register that
// drives the external ALU, then captures the ALU response into the WB register.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : alu_issue_if.slave -- input handshake, ALU operands/response,
//              writeback handshake and payload
module alu_issue
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_issue_if.slave bus
);

  logic [XLEN-1:0]  dec_a;
  logic [XLEN-1:0]  dec_b;
  alu_op_e          dec_op;
  logic [REG_W-1:0] dec_rd;
  logic             dec_illegal;

  issue_bundle_t    ex_q;
  logic             ex_valid;
  logic             ex_advance;
  logic             wb_load;

  logic             wb_valid_q;
  logic [REG_W-1:0] wb_rd_q;
  logic [XLEN-1:0]  wb_data_q;
  logic             wb_zero_q;
  logic             wb_illegal_q;

  alu_decode u_decode (
    .instr       (bus.instr),
    .rs1_data    (bus.rs1_data),
    .rs2_data    (bus.rs2_data),
    .operand_a   (dec_a),
    .operand_b   (dec_b),
    .alu_control (dec_op),
    .rd          (dec_rd),
    .illegal     (dec_illegal)
  );

  // EX can take a new bundle whenever its current entry (if any) moves to WB
  assign ex_advance = !ex_valid || !wb_valid_q || bus.wb_ready;
  assign wb_load    = ex_valid && (!wb_valid_q || bus.wb_ready);

  // EX register: feeds the ALU; holds while WB is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (ex_advance) begin
      ex_valid <= bus.in_valid;
      if (bus.in_valid) begin
        ex_q <= '{operand_a:   dec_a,
                  operand_b:   dec_b,
                  alu_control: dec_op,
                  rd:          dec_rd,
                  illegal:     dec_illegal};
      end
    end
  end

  // WB register: captures the ALU response for the EX entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_zero_q    <= 1'b0;
      wb_illegal_q <= 1'b0;
    end else if (wb_load) begin
      wb_valid_q   <= 1'b1;
      wb_rd_q      <= ex_q.rd;
      wb_data_q    <= bus.alu_result;
      wb_zero_q    <= bus.zero_flag;
      wb_illegal_q <= ex_q.illegal;
    end else if (bus.wb_ready) begin
      wb_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = ex_advance;
  assign bus.operand_a   = ex_q.operand_a;
  assign bus.operand_b   = ex_q.operand_b;
  assign bus.alu_control = ex_q.alu_control;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_zero     = wb_zero_q;
  assign bus.wb_illegal  = wb_illegal_q;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 in_valid  input  1  instruction/operand bundle offered.
REQ-003 in_ready  output  1  bundle accepted at the edge where in_valid && in_ready.
REQ-004 instr  input  32  RV32I instruction word.
REQ-005 rs1_data, rs2_data  input  32 each  register-file read values.
REQ-006 operand_a, operand_b  output  32 each  registered ALU operands.
REQ-007 alu_control  output  4  registered ALU op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
REQ-008 alu_result  input  32, zero_flag  input  1  combinational ALU response to the registered operands.
REQ-009 wb_valid  output  1, wb_ready  input  1  writeback handshake.
REQ-010 wb_rd  output  5, wb_data  output  32, wb_zero  output  1, wb_illegal  output  1  writeback payload.

Function
REQ-011 Two pipeline registers SHALL exist: EX (operands, alu_control, rd, illegal, ex_valid) and WB (wb_* outputs).
REQ-012 ex_advance = !ex_valid || !wb_valid || wb_ready; in_ready SHALL equal !ex_valid || !wb_valid || wb_ready (combinational, no in_valid dependency).
REQ-013 On in_valid && in_ready, EX SHALL load the decoded bundle; if in_ready without in_valid, ex_valid SHALL clear.
REQ-014 When ex_valid && (!wb_valid || wb_ready), WB SHALL load alu_result, zero_flag, rd, illegal and set wb_valid; when wb_valid && wb_ready with no EX entry, wb_valid SHALL clear.
REQ-015 Latency: bundle accepted at edge N SHALL appear with wb_valid at edge N+1's following edge (N+2); back-to-back throughput SHALL be one per cycle while wb_ready=1.
REQ-016 While wb_valid && !wb_ready, WB and EX payloads SHALL hold unchanged; operand_a/operand_b/alu_control SHALL not change while ex_valid and stalled.
REQ-017 Decode OP (0110011): funct3/funct7 000/0000000 ADD, 000/0100000 SUB, 111 AND, 110 OR, 100 XOR, 001/0000000 SLL, 101/0000000 SRL, 101/0100000 SRA, 010 SLT, 011 SLTU; operand_a=rs1_data, operand_b=rs2_data.
REQ-018 Decode OP-IMM (0010011): operand_b = sign-extended instr[31:20]; ADDI/SLTI/SLTIU/XORI/ORI/ANDI per funct3; SLLI/SRLI/SRAI SHALL use operand_b = {27'b0, instr[24:20]} and require instr[31:25] = 0000000 (0100000 for SRAI).
REQ-019 Decode LUI (0110111): operand_a=0, operand_b={instr[31:12],12'b0}, ADD.
REQ-020 Any other opcode/funct combination SHALL be accepted, set illegal=1, operands 0, alu_control ADD; wb_data then equals 0.
REQ-021 wb_rd SHALL be instr[11:7] for every accepted bundle, including illegal ones.
REQ-022 Simultaneous accept and drain SHALL both occur in the same edge without bubble or loss.

Reset
REQ-023 On rst=1 at a clock edge, ex_valid, wb_valid, operand_a, operand_b, alu_control, wb_rd, wb_data, wb_zero, wb_illegal SHALL become 0; rst SHALL override any concurrent handshake.
REQ-024 In-flight EX/WB entries SHALL be discarded on reset; in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-025 A shared package alu_pkg SHALL hold the 4-bit ALU op codes and RV32I opcode constants (OP, OP_IMM, LUI); the ALU and this block SHALL both use it.
REQ-026 Decode SHALL be a combinational sub-module alu_decode (instr, rs1_data, rs2_data -> operands, alu_control, rd, illegal); alu_issue holds the pipeline registers only; the ALU stays external.

Verification
REQ-027 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=3, wb_ready=1 -> alu_control 0000 one cycle after accept; wb_valid two edges after accept with wb_rd=3, wb_data=8, wb_zero=0.
REQ-028 SUB (0x40208133), rs1=rs2=7 -> alu_control 0001, wb_data=0, wb_zero=1; SRAI x1,x1,3 with rs1=0xF0000000 -> alu_control 0111, operand_b=3, wb_data=0xFE000000.
REQ-029 Stream 4 ADDIs with wb_ready=0 from cycle 2 -> in_ready drops after 2 accepted, wb payload stable; raise wb_ready -> remaining results in order, none lost or duplicated.
REQ-030 LUI x5,0x12345 -> operand_a=0, operand_b=0x12345000, wb_rd=5, wb_data=0x12345000; opcode 0x7F -> wb_illegal=1, wb_data=0.
REQ-031 Assert rst with EX and WB both full -> next cycle ex_valid=wb_valid=0, all outputs 0, in_ready=1; SLTIU with imm=-1 (0xFFFFFFFF), rs1=1 then yields wb_data=1.
